seq_frame_tx: RTL
=================

# seq_frame_tx

- Serial frame transmitter; sits directly upstream of the sequence detector/transmitter stage and drives its serial input.
- Frame format: idle-high line, the 6-bit sync preamble 0-1-1-1-1-0, then PAYLOAD_BITS payload bits, an optional parity bit, and GUARD_BITS idle-high bits.
- Payload bytes arrive on a valid/ready byte interface and are serialized LSB-first, one bit per bit_en strobe, so the downstream stage's bit counter stays aligned to the payload.

## Interface
- PAYLOAD_BITS, 1024, payload length in bits; multiple of 8, at most 2047.
- PREAMBLE, 6'b011110, sync pattern; sent MSB first (0,1,1,1,1,0).
- GUARD_BITS, 2, idle-high bits after the frame; at least 1.
- FPGAclk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to send one frame; honoured only in IDLE.
- bit_en  input  1  bit-rate strobe; the line advances one bit per strobe.
- data_in  input  8  payload byte.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  byte accepted when data_valid && data_ready.
- serOut  output  1  registered serial line.
- busy  output  1  high from the accepted start through the last guard bit.
- done  output  1  one-cycle pulse after the last guard bit.
- underrun  output  1  sticky; a payload byte was not available when needed.

## Operation
- States: IDLE, PRE, DATA, PAR, GUARD.
- IDLE:
  - serOut=1, busy=0.
  - start moves to PRE, clears underrun, loads the preamble shifter.
  - start while busy is ignored.
- PRE: sends 6 preamble bits, one per bit_en, then moves to DATA.
- Byte path:
  - One holding register (hold, hold_full) feeds an 8-bit shift register.
  - data_ready = !hold_full && busy && payload bytes still owed; the count owed is PAYLOAD_BITS/8 minus bytes accepted.
  - Bytes may be accepted during PRE, so the first payload byte can be prefetched.
- DATA:
  - Each bit_en shifts out shreg[0]. The 11-bit bit_cnt counts 0..PAYLOAD_BITS-1.
  - On the 8th bit of a byte, shreg reloads from hold. If hold is empty, the next byte is sent as 8'h00 and underrun is set.
  - No stall: frame length is fixed.
- After bit_cnt==PAYLOAD_BITS-1 is sent: go to PAR if parity is compiled in, else GUARD.
- GUARD: sends GUARD_BITS ones, then pulses done and returns to IDLE.
- Bytes offered beyond PAYLOAD_BITS/8 are not accepted; data_ready stays 0.

## Timing
- Reset values: serOut=1, busy=0, done=0, data_ready=0, underrun=0, state=IDLE, all counters 0.
- serOut changes on the FPGAclk edge where bit_en=1 is sampled; latency from strobe to line is 1 cycle.
- busy rises the cycle after start is sampled. The first preamble bit appears at the first bit_en after that.
- Simultaneous events:
  - If a byte handshake and a shreg reload of hold fall in the same cycle, the reload takes the old hold and hold takes the new byte; hold_full stays 1.
  - If bit_en and start coincide in IDLE, only the state transition happens; no bit is sent.
- done coincides with busy falling, on the cycle the last guard bit completes (next bit_en after it).
- Reset asserted mid-frame: serOut returns to 1 immediately (asynchronous) and the frame is abandoned. The downstream stage is expected to be reset alongside.

## Configuration
- SEQ_FRAME_PARITY_EN defined:
  - PAR state present; sends one even-parity bit (XOR of all payload bits) after the payload.
  - Frame length = 6 + PAYLOAD_BITS + 1 + GUARD_BITS strobes.
- Undefined: no PAR state, no parity accumulator; frame length = 6 + PAYLOAD_BITS + GUARD_BITS strobes.

## Structure
- The package seq_frame_pkg holds:
  - the state enum type;
  - the PREAMBLE constant;
  - PREAMBLE_LEN=6;
  - the default PAYLOAD_BITS.
- The package is shared with the detector stage, so both use one sync-pattern definition.
- One sub-module, seq_byte_serializer, holds the holding register, shift register, byte counter and underrun detection. The top level holds the FSM, preamble and guard counters, and parity.

## Test plan
- Reset with rst=0 mid-DATA → serOut=1, busy=0, underrun=0 immediately; the next start sends a full, clean frame.
- start, bit_en every 4 cycles, bytes 8'hA5 then incrementing, always valid → serOut: 0,1,1,1,1,0, then 1,0,1,0,0,1,0,1 (A5 LSB-first) …, 1024 payload bits, then 2 ones; done pulses once; underrun=0.
- Withhold data_valid after byte 3 → byte 4 is sent as 8'h00, underrun=1 until the next start; frame length unchanged.
- start pulses while busy → ignored; exactly one frame; done count=1.
- Payload all 8'hFF with SEQ_FRAME_PARITY_EN → parity bit 0 after the 1024 ones; payload 8'h01 followed by 127×8'h00 → parity bit 1.
- Loop serOut into the detector stage with a shared clock → the detector reaches its pass-through state right after the preamble's final 0 and counts exactly PAYLOAD_BITS strobes.

Source files
------------

// File: rtl/seq_frame_pkg.sv
// Shared definitions for the sequence frame transmitter and the detector stage.
// Holds the FSM state type, the sync pattern and the default frame geometry.
package seq_frame_pkg;

  localparam int PREAMBLE_LEN = 6;
  localparam logic [PREAMBLE_LEN-1:0] PREAMBLE = 6'b011110;
  localparam int PAYLOAD_BITS_DEF = 1024;
  localparam int GUARD_BITS_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

endpackage

// File: rtl/seq_byte_serializer.sv
// Payload byte path: one holding register feeding an 8-bit LSB-first shifter,
// a count of bytes accepted this frame, and sticky underrun detection.
module seq_byte_serializer #(
  parameter int NBYTES = 128
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       busy_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_in_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       bit_o,
  output logic       underrun_o
);

  localparam int BCW = $clog2(NBYTES + 1);
  localparam logic [BCW-1:0] NBYTES_C = BCW'(NBYTES);

  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           underrun_q, underrun_d;
  logic           hs;

  assign data_ready_o = !hold_full_q && busy_i && (byte_cnt_q != NBYTES_C);
  assign hs           = data_valid_i && data_ready_o;
  assign bit_o        = shreg_q[0];
  assign underrun_o   = underrun_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    underrun_d  = underrun_q;
    if (clear_i) begin
      hold_full_d = 1'b0;
      shreg_d     = 8'h00;
      byte_cnt_d  = '0;
      underrun_d  = 1'b0;
    end else begin
      // A reload reads the old hold; a same-cycle handshake refills it below.
      if (load_i) begin
        if (hold_full_q) begin
          shreg_d     = hold_q;
          hold_full_d = 1'b0;
        end else begin
          shreg_d    = 8'h00;
          underrun_d = 1'b1;
        end
      end else if (shift_i) begin
        shreg_d = {1'b0, shreg_q[7:1]};
      end
      if (hs) begin
        hold_d      = data_in_i;
        hold_full_d = 1'b1;
        byte_cnt_d  = byte_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shreg_q     <= 8'h00;
      byte_cnt_q  <= '0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, LSB-first payload, optional even parity
// (define SEQ_FRAME_PARITY_EN), then idle-high guard bits; one bit per bit_en.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE = seq_frame_pkg::PREAMBLE,
  parameter int GUARD_BITS = GUARD_BITS_DEF
) (
  input  logic       FPGAclk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_en,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serOut,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output state_t     state_dbg_o
);

  // Handshake: a payload byte moves on every FPGAclk edge where
  // data_valid && data_ready; data_valid must hold data_in stable until then.

  localparam int GCW = $clog2(GUARD_BITS + 1);
  localparam logic [10:0]    LAST_BIT  = 11'(PAYLOAD_BITS - 1);
  localparam logic [2:0]     LAST_PRE  = 3'(PREAMBLE_LEN - 1);
  localparam logic [GCW-1:0] GUARD_END = GCW'(GUARD_BITS);

  state_t                  state_q, state_d;
  logic [2:0]              pre_cnt_q;
  logic [PREAMBLE_LEN-1:0] pre_sh_q;
  logic [10:0]             bit_cnt_q;
  logic [GCW-1:0]          guard_cnt_q;
  logic                    ser_q;
  logic                    done_q;
`ifdef SEQ_FRAME_PARITY_EN
  logic                    par_q;
`endif

  logic pre_last, bit_last, guard_last;
  logic start_acc, ser_load, ser_shift, frame_end;
  logic ser_bit;

  assign pre_last   = (pre_cnt_q == LAST_PRE);
  assign bit_last   = (bit_cnt_q == LAST_BIT);
  assign guard_last = (guard_cnt_q == GUARD_END);

  always_ff @(posedge FPGAclk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_PRE;
      ST_PRE:   if (bit_en && pre_last) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_en && bit_last) begin
`ifdef SEQ_FRAME_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_GUARD;
`endif
        end
      end
`ifdef SEQ_FRAME_PARITY_EN
      ST_PAR:   if (bit_en) state_d = ST_GUARD;
`endif
      ST_GUARD: if (bit_en && guard_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    start_acc = (state_q == ST_IDLE) && start;
    // Reload the shifter as the preamble ends and after each full byte but the last.
    ser_load  = bit_en && (((state_q == ST_PRE) && pre_last) ||
                           ((state_q == ST_DATA) && (bit_cnt_q[2:0] == 3'd7) && !bit_last));
    ser_shift = bit_en && (state_q == ST_DATA);
    frame_end = bit_en && (state_q == ST_GUARD) && guard_last;
  end

  always_ff @(posedge FPGAclk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q   <= 3'd0;
      pre_sh_q    <= '0;
      bit_cnt_q   <= 11'd0;
      guard_cnt_q <= '0;
      ser_q       <= 1'b1;
      done_q      <= 1'b0;
`ifdef SEQ_FRAME_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      done_q <= frame_end;
      if (start_acc) begin
        pre_cnt_q   <= 3'd0;
        pre_sh_q    <= PREAMBLE;
        bit_cnt_q   <= 11'd0;
        guard_cnt_q <= '0;
`ifdef SEQ_FRAME_PARITY_EN
        par_q       <= 1'b0;
`endif
      end else if (bit_en) begin
        unique case (state_q)
          ST_PRE: begin
            ser_q     <= pre_sh_q[PREAMBLE_LEN-1];
            pre_sh_q  <= {pre_sh_q[PREAMBLE_LEN-2:0], 1'b0};
            pre_cnt_q <= pre_cnt_q + 3'd1;
          end
          ST_DATA: begin
            ser_q     <= ser_bit;
            bit_cnt_q <= bit_cnt_q + 11'd1;
`ifdef SEQ_FRAME_PARITY_EN
            par_q     <= par_q ^ ser_bit;
`endif
          end
`ifdef SEQ_FRAME_PARITY_EN
          ST_PAR:   ser_q <= par_q;
`endif
          ST_GUARD: begin
            ser_q <= 1'b1;
            if (!guard_last) guard_cnt_q <= guard_cnt_q + GCW'(1);
          end
          default:  ser_q <= 1'b1;
        endcase
      end
    end
  end

  seq_byte_serializer #(
    .NBYTES(PAYLOAD_BITS / 8)
  ) u_ser (
    .clk_i        (FPGAclk),
    .rst_ni       (rst),
    .clear_i      (start_acc),
    .busy_i       (busy),
    .load_i       (ser_load),
    .shift_i      (ser_shift),
    .data_in_i    (data_in),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .bit_o        (ser_bit),
    .underrun_o   (underrun)
  );

  assign serOut      = ser_q;
  assign done        = done_q;
  assign state_dbg_o = state_q;

endmodule
